// File: rtl/spc1_cfg_tx_if.sv
// spc1_cfg_tx_if: host-side handshake and spc1-side serial signals for spc1_cfg_tx.
// Optional SPC1_CFG_TX_QUEUE_EN adds the Pending status line.
interface spc1_cfg_tx_if #(
  parameter int WIDTH = 11
);
  logic             Start;
  logic [WIDTH-1:0] Conf;
  logic             Cfg_out;
  logic             Strobe;
  logic             Busy;
  logic             Done;
`ifdef SPC1_CFG_TX_QUEUE_EN
  logic             Pending;

  modport master (output Start, Conf, input Cfg_out, Strobe, Busy, Done, Pending);
  modport slave  (input Start, Conf, output Cfg_out, Strobe, Busy, Done, Pending);
`else
  modport master (output Start, Conf, input Cfg_out, Strobe, Busy, Done);
  modport slave  (input Start, Conf, output Cfg_out, Strobe, Busy, Done);
`endif
endinterface

// File: rtl/spc1_cfg_tx.sv
// spc1_cfg_tx: shifts a WIDTH-bit configuration word LSB first into an spc1
// chain, then holds the load strobe for STROBE_CYCLES cycles.
// Optional macro SPC1_CFG_TX_QUEUE_EN adds a one-deep holding register and Pending.
module spc1_cfg_tx #(
  parameter int WIDTH         = 11,
  parameter int STROBE_CYCLES = 1
) (
  input  logic          Clk,
  input  logic          Resetn,
  spc1_cfg_tx_if.slave  bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     STB_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STROBE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bcnt_q,  bcnt_d;
  logic [3:0]       scnt_q,  scnt_d;
  logic             done_q,  done_d;
  logic             last_strobe;
`ifdef SPC1_CFG_TX_QUEUE_EN
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             pend_q,  pend_d;
`endif

  assign last_strobe = (state_q == ST_STROBE) && (scnt_q == STB_LAST);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      done_q  <= 1'b0;
`ifdef SPC1_CFG_TX_QUEUE_EN
      hold_q  <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      done_q  <= done_d;
`ifdef SPC1_CFG_TX_QUEUE_EN
      hold_q  <= hold_d;
      pend_q  <= pend_d;
`endif
    end
  end

  // Next-state logic: shift, strobe, then launch the next word if one is ready
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
`ifdef SPC1_CFG_TX_QUEUE_EN
    hold_d  = hold_q;
    pend_d  = pend_q;
`endif

    case (state_q)
      ST_SHIFT: begin
        // Last bit stays in shift_q[0] so Cfg_out holds Conf[WIDTH-1] during the strobe
        if (bcnt_q == BIT_LAST) begin
          state_d = ST_STROBE;
          scnt_d  = '0;
        end else begin
          shift_d = shift_q >> 1;
          bcnt_d  = bcnt_q + 1'b1;
        end
      end
      ST_STROBE: begin
        if (last_strobe) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          scnt_d  = scnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A word launches from IDLE or straight out of the final strobe cycle,
    // which gives back-to-back words with no idle gap.
    if ((state_q == ST_IDLE) || last_strobe) begin
`ifdef SPC1_CFG_TX_QUEUE_EN
      if (pend_q) begin
        state_d = ST_SHIFT;
        shift_d = hold_q;
        bcnt_d  = '0;
        pend_d  = 1'b0;
      end else
`endif
      if (bus.Start) begin
        state_d = ST_SHIFT;
        shift_d = bus.Conf;
        bcnt_d  = '0;
      end
    end
`ifdef SPC1_CFG_TX_QUEUE_EN
    else if (bus.Start && !pend_q) begin
      hold_d = bus.Conf;
      pend_d = 1'b1;
    end
`endif
  end

  assign bus.Cfg_out = (state_q == ST_IDLE) ? 1'b0 : shift_q[0];
  assign bus.Strobe  = (state_q == ST_STROBE);
  assign bus.Busy    = (state_q != ST_IDLE);
  assign bus.Done    = done_q;
`ifdef SPC1_CFG_TX_QUEUE_EN
  assign bus.Pending = pend_q;
`endif

endmodule

// File: doc/spc1_cfg_tx.md
# spc1_cfg_tx

Serial configuration transmitter for the `spc1` serial-to-parallel configuration register. It accepts a WIDTH-bit parallel configuration word and shifts it out LSB first on a single data line, one bit per clock. It then pulses the load strobe so the `spc1` receiver transfers its shift chain to the parallel outputs (F, IQ, G, CE, GCP). It sits between the host/sequencer logic and the `spc1` instance, and both share the same clock.

## Interface
- `WIDTH`, 11, number of configuration bits per word; matches the `spc1` chain length.
- `STROBE_CYCLES`, 1, number of cycles Strobe is held high after the last bit; legal range 1..15.

Clock and reset, and all ports:
- `Clk`  in  1  Clock. All state changes on the rising edge.
- `Resetn`  in  1  Reset. Synchronous, active-low.
- `Start`  in  1  Request to send `Conf`. Sampled on every rising edge.
- `Conf`  in  WIDTH  Configuration word. Captured on the accepting edge only.
- `Cfg_out`  out  1  Serial data to `spc1` `Cfg_in`.
- `Strobe`  out  1  Load strobe to `spc1` `Strobe`.
- `Busy`  out  1  High while a word is being shifted or strobed.
- `Done`  out  1  One-cycle pulse after each completed word.

## Operation
- States:
  - IDLE: Cfg_out=0, Strobe=0, Busy=0.
  - SHIFT: Cfg_out = shift_reg[0], Busy=1; bit counter runs 0..WIDTH-1.
  - STROBE: Strobe=1, Busy=1; Cfg_out holds Conf[WIDTH-1]; cycle counter runs 0..STROBE_CYCLES-1.
- IDLE -> SHIFT when Start=1. Conf is loaded into shift_reg and the bit counter is cleared.
- SHIFT:
  - On each edge, shift_reg shifts right by one and the counter increments.
  - When the counter reaches WIDTH-1, the next state is STROBE; no shift happens on that edge.
- STROBE -> IDLE after STROBE_CYCLES cycles. Done=1 for exactly the first cycle after leaving STROBE.
- Start while Busy=1 is ignored (see Configuration for the alternative). Conf changes while Busy have no effect.
- Counters are sized ceil(log2(WIDTH)) and 4 bits. The bit counter never wraps past WIDTH-1.
- Resetn=0 on any edge returns the block to IDLE, including mid-SHIFT or mid-STROBE:
  - Cfg_out=0, Strobe=0, Busy=0, Done=0.
  - shift_reg and counters are cleared.
  - No partial strobe is issued.
- Reset values: all outputs 0.

## Timing
- Edge E0: Start=1 is accepted with Busy=0.
- Cycles E0..E(WIDTH-1): Cfg_out = Conf[k] during cycle E(k)→E(k+1).
  - Each bit is stable for a full clock, so `spc1` samples bit k on edge E(k+1).
- Edge E(WIDTH): Strobe rises and stays high for STROBE_CYCLES cycles.
- Edge E(WIDTH+STROBE_CYCLES): Strobe falls, Busy falls, Done=1 for one cycle.
- Start on the same edge Done is high is accepted; the next word starts back-to-back.
- Throughput: one word per WIDTH+STROBE_CYCLES cycles.

## Configuration
- Macro: `SPC1_CFG_TX_QUEUE_EN`.
- Defined:
  - Adds a one-deep holding register and output `Pending` (out, 1).
  - Start while Busy=1 and Pending=0 captures Conf into the holding register and sets Pending=1.
  - Start while Pending=1 is ignored; the first queued word is kept.
  - At the end of STROBE, if Pending=1:
    - Done pulses and Busy stays 1.
    - The state goes directly to SHIFT with the held word, and Cfg_out = held[0] in that cycle.
    - Pending clears.
  - Reset clears Pending and the holding register.
- Undefined: no holding register, no `Pending` port; Start while Busy is dropped.

## Test plan
- Reset then send: Resetn low 1 cycle, then Start with Conf=11'b10101100001.
  - Cfg_out sequence 1,0,0,0,0,1,1,0,1,0,1 on cycles E0..E10.
  - Strobe=1 on cycle E11 only.
  - Done on E12; Busy=0 after E12.
  - The attached `spc1` shows F=4'b0001, IQ=0, G=3'b011, CE=1, GCP=2'b10.
- Ignored start: Start pulsed at E5 with Conf=11'h7FF (queue disabled). Serial data is unchanged from the first word and exactly one Done is produced.
- Back-to-back: Start held high continuously with Conf=11'h555, then 11'h2AA.
  - Second word bit 0 appears at E12.
  - Period is 12 cycles; Done pulses at E12 and E24.
- Reset mid-shift: Resetn=0 at E6.
  - Next cycle: Cfg_out=0, Strobe=0, Busy=0.
  - No Strobe pulse for the aborted word; a new Start at E8 sends a full 11 bits.
- STROBE_CYCLES=3: Strobe is high for cycles E11..E13 and Done pulses at E14.
- QUEUE_EN: Start 11'h001 at E0, Start 11'h400 at E4.
  - Pending=1 from E4.
  - At E12: Done=1, Busy stays 1, Cfg_out=0 (bit 0 of 11'h400).
  - Cfg_out=1 at E22, Strobe at E23.
